mem_access_unit: RTL and testbench

Load/store initiator that drives the data port of the dual-port instruction/data memory on behalf of the MIPS execute stage. It accepts byte-addressed load/store requests of byte, halfword or word size, converts them to word-addressed memory cycles, and sign- or zero-extends load data. It performs read-modify-write for sub-word stores and returns one response per request. It sits between the pipeline's memory stage and the memory's `d_*` port.

---
 rtl/mau_pkg.sv | 41 ++++
 rtl/mau_if.sv | 38 +++
 rtl/mau_lane_align.sv | 53 +++++
 rtl/mem_access_unit.sv | 148 ++++++++++++++
 tb/tb_mem_access_unit.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/mau_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mau_pkg                                                      |
// | Description : Shared encodings, FSM states and lane helper for the         |
// |               memory access unit.                                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mau_pkg;

   localparam int MAU_MEM_WORDS = 1024;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10,
      SIZE_RSVD = 2'b11
   } mau_size_e;

   typedef logic [2:0] mau_state_t;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_ACCESS = 3'd1;
   localparam logic [2:0] ST_RMW_RD = 3'd2;
   localparam logic [2:0] ST_RMW_WR = 3'd3;
   localparam logic [2:0] ST_RESP   = 3'd4;
   localparam logic [2:0] ST_ERR    = 3'd5;

   // Big-endian lanes: byte k sits (3-k)*8 bits above bit 0, half at addr[1]=0 sits 16 up.
   function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] addr_lo);
      logic [4:0] s;
      s = 5'd0;
      case (size)
         SIZE_BYTE: s = {~addr_lo, 3'b000};
         SIZE_HALF: s = {~addr_lo[1], 4'b0000};
         default:   s = 5'd0;
      endcase
      return s;
   endfunction

endpackage : mau_pkg
`default_nettype wire

// File: rtl/mau_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mau_if                                                       |
// | Description : Request/response handshake and memory data-port bundle.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface mau_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic        d_read_en;
   logic        d_write_en;
   logic [31:0] d_addr;
   logic [31:0] d_write_data;
   logic [31:0] d_data_in;

   // The unit itself
   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, d_data_in,
      output req_ready, resp_valid, resp_err, resp_rdata,
             d_read_en, d_write_en, d_addr, d_write_data
   );

   // Pipeline plus memory, seen from outside the unit
   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, d_data_in,
      input  req_ready, resp_valid, resp_err, resp_rdata,
             d_read_en, d_write_en, d_addr, d_write_data
   );
endinterface : mau_if
`default_nettype wire

// File: rtl/mau_lane_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mau_lane_align                                               |
// | Description : Combinational load lane extract/extend and sub-word store    |
// |               merge for big-endian byte lanes.                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mau_lane_align
   import mau_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic        is_signed,
   input  logic [31:0] rdata,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merge_data
);

   logic [4:0]  shamt;
   logic [31:0] shifted;
   logic [31:0] lane_mask;
   logic        sign_bit;

   always_comb begin
      shamt      = lane_shift(size, addr_lo);
      shifted    = rdata >> shamt;
      lane_mask  = 32'hFFFF_FFFF;
      sign_bit   = 1'b0;
      load_data  = rdata;
      merge_data = wdata;
      case (size)
         SIZE_BYTE: begin
            sign_bit   = is_signed & shifted[7];
            load_data  = (shifted & 32'h0000_00FF) | ({32{sign_bit}} & 32'hFFFF_FF00);
            lane_mask  = 32'h0000_00FF << shamt;
            merge_data = (rdata & ~lane_mask) | ((wdata & 32'h0000_00FF) << shamt);
         end
         SIZE_HALF: begin
            sign_bit   = is_signed & shifted[15];
            load_data  = (shifted & 32'h0000_FFFF) | ({32{sign_bit}} & 32'hFFFF_0000);
            lane_mask  = 32'h0000_FFFF << shamt;
            merge_data = (rdata & ~lane_mask) | ((wdata & 32'h0000_FFFF) << shamt);
         end
         default: begin
            load_data  = rdata;
            merge_data = wdata;
         end
      endcase
   end

endmodule : mau_lane_align
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_access_unit                                              |
// | Description : Load/store initiator for the data port of the I/D memory;    |
// |               word/half/byte access with read-modify-write sub-word store. |
// |               Optional misalignment trap: MAU_MISALIGN_TRAP_EN.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_access_unit
   import mau_pkg::*;
#(
   parameter int MEM_WORDS = MAU_MEM_WORDS
)(
   input  logic  clk,
   input  logic  rst_n,
   mau_if.slave  bus
);

   localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

   mau_state_t  state_q, state_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        signed_q, signed_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] merge_q, merge_d;

   logic        accept;
   logic        req_err;
   logic        req_subword_st;
   logic [31:0] lane_load;
   logic [31:0] lane_merge;

   mau_lane_align u_lane_align (
      .size       (size_q),
      .addr_lo    (addr_q[1:0]),
      .is_signed  (signed_q),
      .rdata      (bus.d_data_in),
      .wdata      (wdata_q),
      .load_data  (lane_load),
      .merge_data (lane_merge)
   );

   // Ready is masked by reset so nothing upstream sees the unit as idle during reset.
   assign bus.req_ready  = rst_n && (state_q == ST_IDLE);
   assign accept         = bus.req_valid && bus.req_ready;
   assign req_subword_st = bus.req_we && (bus.req_size != SIZE_WORD);

   always_comb begin
      req_err = 1'b0;
      if (bus.req_size == SIZE_RSVD)
         req_err = 1'b1;
      if ({1'b0, bus.req_addr} >= ADDR_LIMIT)
         req_err = 1'b1;
`ifdef MAU_MISALIGN_TRAP_EN
      if ((bus.req_size == SIZE_HALF) && bus.req_addr[0])
         req_err = 1'b1;
      if ((bus.req_size == SIZE_WORD) && (bus.req_addr[1:0] != 2'b00))
         req_err = 1'b1;
`endif
   end

   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      size_d   = size_q;
      signed_d = signed_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      merge_d  = merge_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               we_d     = bus.req_we;
               size_d   = bus.req_size;
               signed_d = bus.req_signed;
               addr_d   = bus.req_addr;
               wdata_d  = bus.req_wdata;
               rdata_d  = 32'd0;
               if (req_err)
                  state_d = ST_ERR;
               else if (req_subword_st)
                  state_d = ST_RMW_RD;
               else
                  state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (!we_q)
               rdata_d = lane_load;
            state_d = ST_RESP;
         end
         ST_RMW_RD: begin
            merge_d = lane_merge;
            state_d = ST_RMW_WR;
         end
         ST_RMW_WR: state_d = ST_RESP;
         ST_RESP:   state_d = ST_IDLE;
         ST_ERR:    state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         we_q     <= 1'b0;
         size_q   <= SIZE_BYTE;
         signed_q <= 1'b0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         rdata_q  <= 32'd0;
         merge_q  <= 32'd0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         size_q   <= size_d;
         signed_q <= signed_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         merge_q  <= merge_d;
      end
   end

   // Enables decode straight from the state flop, so reset drops them asynchronously.
   assign bus.d_read_en  = ((state_q == ST_ACCESS) && !we_q) || (state_q == ST_RMW_RD);
   assign bus.d_write_en = ((state_q == ST_ACCESS) &&  we_q) || (state_q == ST_RMW_WR);

   assign bus.d_addr = (bus.d_read_en || bus.d_write_en) ? {2'b00, addr_q[31:2]} : 32'd0;

   always_comb begin
      bus.d_write_data = 32'd0;
      if ((state_q == ST_ACCESS) && we_q)
         bus.d_write_data = wdata_q;
      else if (state_q == ST_RMW_WR)
         bus.d_write_data = merge_q;
   end

   assign bus.resp_valid = (state_q == ST_RESP) || (state_q == ST_ERR);
   assign bus.resp_err   = (state_q == ST_ERR);
   assign bus.resp_rdata = (state_q == ST_RESP) ? rdata_q : 32'd0;

endmodule : mem_access_unit
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_access_unit                                           |
// | Description : Directed scoreboard bench for mem_access_unit with a         |
// |               behavioural word memory on the data port.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_access_unit;
   import mau_pkg::*;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          lat;
   } exp_t;

   logic clk;
   logic rst_n;
   mau_if bus ();

   mem_access_unit #(.MEM_WORDS(1024)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [31:0] mem [0:1023];
   logic        ld_en;
   logic [9:0]  ld_addr;
   logic [31:0] ld_data;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   viol     = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ld_en)
         mem[ld_addr] <= ld_data;
      else if (bus.d_write_en)
         mem[bus.d_addr[9:0]] <= bus.d_write_data;
   end
   assign bus.d_data_in = mem[bus.d_addr[9:0]];

   // Port-level invariants: exclusive enables, idle address parked at zero.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.d_read_en && bus.d_write_en) viol <= viol + 1;
         if (!bus.d_read_en && !bus.d_write_en && bus.d_addr != 32'd0) viol <= viol + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge on which the response was seen.
   task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                         input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic exp_err, input logic [31:0] exp_rdata, input int exp_lat,
                         output int n_rd, output int n_wr,
                         output logic [31:0] w_addr, output logic [31:0] w_data);
      exp_t e;
      exp_t got_e;
      int   lat_seen;
      int   w;
      bit   got;
      e.err = exp_err; e.rdata = exp_rdata; e.lat = exp_lat;
      sb.push_back(e);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_size   = size;
      bus.req_signed = sgn;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      w = 0;
      while (!bus.req_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      n_rd = 0; n_wr = 0; w_addr = 32'd0; w_data = 32'd0;
      got = 1'b0; lat_seen = 0;
      for (int lat = 1; lat <= 8 && !got; lat++) begin
         @(negedge clk);
         if (bus.d_read_en) n_rd++;
         if (bus.d_write_en) begin
            n_wr++;
            w_addr = bus.d_addr;
            w_data = bus.d_write_data;
         end
         if (bus.resp_valid) begin
            got = 1'b1;
            lat_seen = lat;
         end
      end
      chk({tag, "_resp"}, 32'(got), 32'd1);
      if (got) begin
         got_e = sb.pop_front();
         chk({tag, "_lat"}, 32'(lat_seen), 32'(got_e.lat));
         chk({tag, "_err"}, 32'(bus.resp_err), 32'(got_e.err));
         chk({tag, "_rdata"}, bus.resp_rdata, got_e.rdata);
      end
   endtask

   initial begin : main
      int          nr, nw, resp_seen;
      logic [31:0] wa, wd;

      rst_n = 1'b0;
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
      bus.req_signed = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
      ld_en = 1'b1; ld_addr = 10'd0; ld_data = 32'd0;
      for (int i = 0; i < 1024; i++) begin
         @(negedge clk);
         ld_addr = 10'(i);
         ld_data = (i == 4) ? 32'h1122_3344 : (i == 5) ? 32'h80FF_7F01 : 32'd0;
      end
      @(negedge clk);
      ld_en = 1'b0;

      chk("rst_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
      chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
      chk("rst_en", {30'd0, bus.d_read_en, bus.d_write_en}, 32'd0);
      chk("rst_d_addr", bus.d_addr, 32'd0);
      chk("rst_d_wdata", bus.d_write_data, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_ready", 32'(bus.req_ready), 32'd1);

      do_req("lb_s_14", 1'b0, SIZE_BYTE, 1'b1, 32'h14, 32'd0, 1'b0, 32'hFFFF_FF80, 2, nr, nw, wa, wd);
      chk("lb_s_14_nrd", 32'(nr), 32'd1);
      chk("lb_s_14_nwr", 32'(nw), 32'd0);
      do_req("lbu_14", 1'b0, SIZE_BYTE, 1'b0, 32'h14, 32'd0, 1'b0, 32'h0000_0080, 2, nr, nw, wa, wd);
      do_req("lb_s_15", 1'b0, SIZE_BYTE, 1'b1, 32'h15, 32'd0, 1'b0, 32'hFFFF_FFFF, 2, nr, nw, wa, wd);
      do_req("lbu_17", 1'b0, SIZE_BYTE, 1'b0, 32'h17, 32'd0, 1'b0, 32'h0000_0001, 2, nr, nw, wa, wd);
      do_req("lh_s_14", 1'b0, SIZE_HALF, 1'b1, 32'h14, 32'd0, 1'b0, 32'hFFFF_80FF, 2, nr, nw, wa, wd);
      do_req("lh_s_16", 1'b0, SIZE_HALF, 1'b1, 32'h16, 32'd0, 1'b0, 32'h0000_7F01, 2, nr, nw, wa, wd);
      do_req("lhu_14", 1'b0, SIZE_HALF, 1'b0, 32'h14, 32'd0, 1'b0, 32'h0000_80FF, 2, nr, nw, wa, wd);

      do_req("sb_11", 1'b1, SIZE_BYTE, 1'b0, 32'h11, 32'h0000_00AB, 1'b0, 32'd0, 3, nr, nw, wa, wd);
      chk("sb_11_nrd", 32'(nr), 32'd1);
      chk("sb_11_nwr", 32'(nw), 32'd1);
      chk("sb_11_waddr", wa, 32'd4);
      chk("sb_11_wdata", wd, 32'h11AB_3344);
      do_req("lw_10_a", 1'b0, SIZE_WORD, 1'b0, 32'h10, 32'd0, 1'b0, 32'h11AB_3344, 2, nr, nw, wa, wd);

      do_req("sh_12", 1'b1, SIZE_HALF, 1'b0, 32'h12, 32'h1234_CAFE, 1'b0, 32'd0, 3, nr, nw, wa, wd);
      chk("sh_12_wdata", wd, 32'h11AB_CAFE);
      do_req("lw_10_b", 1'b0, SIZE_WORD, 1'b0, 32'h10, 32'd0, 1'b0, 32'h11AB_CAFE, 2, nr, nw, wa, wd);

      do_req("sw_10", 1'b1, SIZE_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'd0, 2, nr, nw, wa, wd);
      chk("sw_10_nwr", 32'(nw), 32'd1);
      chk("sw_10_nrd", 32'(nr), 32'd0);
      chk("sw_10_waddr", wa, 32'd4);
      chk("sw_10_wdata", wd, 32'hDEAD_BEEF);
      do_req("lw_10_c", 1'b0, SIZE_WORD, 1'b0, 32'h10, 32'd0, 1'b0, 32'hDEAD_BEEF, 2, nr, nw, wa, wd);

`ifdef MAU_MISALIGN_TRAP_EN
      do_req("lw_12", 1'b0, SIZE_WORD, 1'b0, 32'h12, 32'd0, 1'b1, 32'd0, 1, nr, nw, wa, wd);
      chk("lw_12_nrd", 32'(nr), 32'd0);
`else
      do_req("lw_12", 1'b0, SIZE_WORD, 1'b0, 32'h12, 32'd0, 1'b0, 32'hDEAD_BEEF, 2, nr, nw, wa, wd);
      chk("lw_12_nrd", 32'(nr), 32'd1);
`endif

      do_req("lw_1000", 1'b0, SIZE_WORD, 1'b0, 32'h1000, 32'd0, 1'b1, 32'd0, 1, nr, nw, wa, wd);
      chk("lw_1000_en", 32'(nr + nw), 32'd0);
      do_req("sb_1003", 1'b1, SIZE_BYTE, 1'b0, 32'h1003, 32'h55, 1'b1, 32'd0, 1, nr, nw, wa, wd);
      chk("sb_1003_en", 32'(nr + nw), 32'd0);
      do_req("rsvd", 1'b0, SIZE_RSVD, 1'b0, 32'h10, 32'd0, 1'b1, 32'd0, 1, nr, nw, wa, wd);
      chk("rsvd_en", 32'(nr + nw), 32'd0);

      do_req("sw_ffc", 1'b1, SIZE_WORD, 1'b0, 32'hFFC, 32'h5A5A_5A5A, 1'b0, 32'd0, 2, nr, nw, wa, wd);
      chk("sw_ffc_waddr", wa, 32'h3FF);
      do_req("lw_ffc", 1'b0, SIZE_WORD, 1'b0, 32'hFFC, 32'd0, 1'b0, 32'h5A5A_5A5A, 2, nr, nw, wa, wd);

      // Reset while the merged word is on the write port.
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = SIZE_BYTE;
      bus.req_signed = 1'b0; bus.req_addr = 32'h14; bus.req_wdata = 32'h55;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      chk("rst_mid_rmwrd", 32'(bus.d_read_en), 32'd1);
      @(negedge clk);
      chk("rst_mid_rmwwr", 32'(bus.d_write_en), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_wr_off", 32'(bus.d_write_en), 32'd0);
      chk("rst_mid_addr", bus.d_addr, 32'd0);
      resp_seen = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (bus.resp_valid) resp_seen++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if (bus.resp_valid) resp_seen++;
      end
      chk("rst_mid_noresp", 32'(resp_seen), 32'd0);
      chk("rst_mid_ready", 32'(bus.req_ready), 32'd1);
      do_req("lw_14_after", 1'b0, SIZE_WORD, 1'b0, 32'h14, 32'd0, 1'b0, 32'h80FF_7F01, 2, nr, nw, wa, wd);

      chk("port_invariants", 32'(viol), 32'd0);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule : tb_mem_access_unit
`default_nettype wire
